// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch/LSU memory arbiter: port identifiers,
// word-index shift and the starvation-counter width helper.
package mem_arbiter_pkg;

   localparam int unsigned PORT_IF    = 0;
   localparam int unsigned PORT_LS    = 1;
   localparam int unsigned N_PORTS    = 2;
   localparam int unsigned WORD_SHIFT = 2;

   function automatic int unsigned starve_w(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: LSU wins contention unless fetch has been
// denied STARVE_LIMIT consecutive cycles. Output grant is one-hot by port ID.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned STARVE_W     = 3
) (
   input  logic                i_if_req,
   input  logic                i_ls_req,
   input  logic [STARVE_W-1:0] i_starve_cnt,
   output logic [N_PORTS-1:0]  o_gnt
);

   logic w_if_starved;

   assign w_if_starved = (i_starve_cnt == STARVE_W'(STARVE_LIMIT));

   always_comb begin
      o_gnt = '0;
      if (i_if_req && i_ls_req) begin
         if (w_if_starved) o_gnt[PORT_IF] = 1'b1;
         else              o_gnt[PORT_LS] = 1'b1;
      end else begin
         o_gnt[PORT_IF] = i_if_req;
         o_gnt[PORT_LS] = i_ls_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port word memory between instruction fetch (read-only) and
// the load/store unit; one grant per cycle, registered response one cycle later.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_err,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [ADDR_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  ls_err,
   output logic                  mem_we,
   output logic [31:0]           mem_address,
   output logic [31:0]           mem_data_in,
   input  logic [31:0]           mem_data_out
);

   localparam int unsigned STARVE_W = starve_w(STARVE_LIMIT);

   logic [STARVE_W-1:0]   r_starve_cnt;
   logic                  r_if_rvalid, r_if_err, r_ls_rvalid, r_ls_err;
   logic [DATA_WIDTH-1:0] r_if_rdata, r_ls_rdata;

   logic [N_PORTS-1:0]    w_gnt;
   logic                  w_if_req, w_ls_req;
   logic                  w_if_mis, w_ls_mis;
   logic [ADDR_WIDTH-1:0] w_sel_addr;

   assign w_if_req = if_req && !reset;
   assign w_ls_req = ls_req && !reset;
   assign w_if_mis = (if_addr[1:0] != 2'b00);
   assign w_ls_mis = (ls_addr[1:0] != 2'b00);

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .STARVE_W    (STARVE_W)
   ) u_pick (
      .i_if_req    (w_if_req),
      .i_ls_req    (w_ls_req),
      .i_starve_cnt(r_starve_cnt),
      .o_gnt       (w_gnt)
   );

   assign if_gnt = w_gnt[PORT_IF];
   assign ls_gnt = w_gnt[PORT_LS];

   always_comb begin
      w_sel_addr  = '0;
      mem_we      = 1'b0;
      mem_address = '0;
      mem_data_in = '0;
      if (w_gnt[PORT_LS])      w_sel_addr = ls_addr;
      else if (w_gnt[PORT_IF]) w_sel_addr = if_addr;
      if (w_gnt != '0) mem_address = 32'(w_sel_addr >> WORD_SHIFT);
      if (w_gnt[PORT_LS] && ls_we) begin
         mem_data_in = 32'(ls_wdata);
         mem_we      = !w_ls_mis;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_starve_cnt <= '0;
         r_if_rvalid  <= 1'b0;
         r_if_err     <= 1'b0;
         r_if_rdata   <= '0;
         r_ls_rvalid  <= 1'b0;
         r_ls_err     <= 1'b0;
         r_ls_rdata   <= '0;
      end else begin
         if (!if_req || if_gnt)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT))
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
         r_if_rvalid <= if_gnt;
         r_if_err    <= if_gnt && w_if_mis;
         r_if_rdata  <= (if_gnt && !w_if_mis) ? DATA_WIDTH'(mem_data_out) : '0;
         r_ls_rvalid <= ls_gnt;
         r_ls_err    <= ls_gnt && w_ls_mis;
         r_ls_rdata  <= (ls_gnt && !ls_we && !w_ls_mis) ? DATA_WIDTH'(mem_data_out) : '0;
      end
   end

   // Responses are masked while reset is high so one registered just before
   // reset asserts is dropped rather than presented during the reset cycle.
   assign if_rvalid = r_if_rvalid && !reset;
   assign if_err    = r_if_err && !reset;
   assign if_rdata  = reset ? '0 : r_if_rdata;
   assign ls_rvalid = r_ls_rvalid && !reset;
   assign ls_err    = r_ls_err && !reset;
   assign ls_rdata  = reset ? '0 : r_ls_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port word memory between the instruction-fetch unit (read-only) and the load/store unit (read/write). It accepts one request per cycle, translates byte addresses to word indices, and returns a registered response one cycle after grant. Data priority is bounded by a starvation counter so fetch always progresses. It sits between the core's fetch/LSU stages and the memory block, and owns that block's `we`/`address`/`data_in` inputs.

## Interface
- `ADDR_WIDTH`, 32: requester byte-address width.
- `DATA_WIDTH`, 32: data word width.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch wins (≥1).
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held with stable `if_addr` until `if_gnt`.
- `if_addr` in ADDR_WIDTH: fetch byte address.
- `if_gnt` out 1: combinational; request accepted this cycle.
- `if_rvalid` out 1: response pulse, cycle after grant.
- `if_rdata` out DATA_WIDTH: read data, valid with `if_rvalid`.
- `if_err` out 1: misaligned-address error, valid with `if_rvalid`.
- `ls_req` in 1: LSU request; held with stable payload until `ls_gnt`.
- `ls_we` in 1: 1 = write, 0 = read.
- `ls_addr` in ADDR_WIDTH: LSU byte address.
- `ls_wdata` in DATA_WIDTH: write data.
- `ls_gnt` out 1: combinational accept.
- `ls_rvalid` out 1: response/ack pulse, cycle after grant (reads and writes).
- `ls_rdata` out DATA_WIDTH: read data; 0 for writes and errors.
- `ls_err` out 1: misaligned-address error.
- `mem_we` out 1: memory write enable.
- `mem_address` out 32: word index `{2'b0, addr[31:2]}` of granted request; 0 when idle.
- `mem_data_in` out 32: granted write data; 0 otherwise.
- `mem_data_out` in 32: combinational memory read data.

## Operation
- Per cycle, at most one grant. Selection: only one requesting → it wins; both → LSU wins unless `starve_cnt == STARVE_LIMIT`, then fetch wins.
- `starve_cnt`: increments (saturating at STARVE_LIMIT) each cycle `if_req && !if_gnt`; clears on `if_gnt` or when `if_req` low.
- Alignment: `addr[1:0] != 0` → request still granted, memory untouched (`mem_we = 0`), response carries `err = 1`, `rdata = 0`.
- Aligned read: `mem_data_out` captured at grant edge into response register.
- Aligned write: `mem_we = 1` during grant cycle; ack `rvalid` with `rdata = 0`, `err = 0`.
- Response registers are per-port; `rvalid` is a one-cycle pulse, no backpressure on responses.
- Reset: `starve_cnt = 0`; all `rvalid`, `err`, `rdata` = 0; grants inactive. A response pending at reset is dropped.

## Timing
- Grant cycle N (combinational from `*_req`); response in N+1. Latency 1, throughput 1 request/cycle.
- Back-to-back: new grant allowed in N+1 while N's response is presented.
- LSU write in N, fetch read of same word in N+1 → returns new data.
- Read and write to same word never share a cycle (single grant).
- Reset asserted in cycle N: no grants in N, all outputs 0 from N+1.
- Requester dropping `req` before `gnt` is illegal; assert in bench.

## Structure
- Package `mem_arbiter_pkg`: port-ID constants (`PORT_IF`, `PORT_LS`), `STARVE_W = $clog2(STARVE_LIMIT+1)`, word-index shift constant.
- Sub-module `mem_arb_pick`: combinational priority picker (inputs: both reqs, `starve_cnt`; outputs: one-hot grant). Counter, address mux and response registers stay in the top.

## Test plan
- Reset then fetch-only read of addr 0x8 (mem[2]=0xDEADBEEF) → `if_gnt` same cycle, `mem_address=2`, next cycle `if_rvalid=1`, `if_rdata=0xDEADBEEF`.
- LSU write 0x12345678 to 0x10, fetch read 0x10 next cycle → `mem_we=1,mem_address=4`, then `if_rdata=0x12345678`.
- Both request continuously, STARVE_LIMIT=4 → LSU granted 4 cycles, fetch granted 5th, pattern repeats; fetch never waits >4 cycles.
- LSU read at 0x6 → `mem_we=0`, next cycle `ls_rvalid=1, ls_err=1, ls_rdata=0`; memory contents unchanged.
- Reset asserted the cycle after an LSU read grant → `ls_rvalid` stays 0, `starve_cnt=0`, no grant during reset.
- Alternating back-to-back LSU writes/reads over indices 0–31 → every read returns last written value, one `rvalid` per grant.
